// File: rtl/demux_rr_lanes.sv
// Round-robin serial-to-lane demux: collects DATA_W words into LANES lanes and
// emits each full (or flushed partial) group with a one-cycle per-lane valid.
module demux_rr_lanes #(
  parameter  int DATA_W = 8,
  parameter  int LANES  = 4,
  parameter  int CNT_W  = 8,
  localparam int PTR_W  = $clog2(LANES)
) (
  input  logic                      clk_4f,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      valid_in,
  input  logic                      flush,
  output logic [LANES*DATA_W-1:0]   data_out,
  output logic [LANES-1:0]          valid_out,
  output logic                      out_strobe,
  output logic                      busy,
  output logic [CNT_W-1:0]          group_cnt
);

  logic [PTR_W-1:0]        r_ptr;
  logic [LANES-1:0]        r_mask;
  logic [DATA_W-1:0]       r_buf [LANES];
  logic [LANES*DATA_W-1:0] r_dout;
  logic [LANES-1:0]        r_vout;
  logic                    r_busy;
  logic [CNT_W-1:0]        r_cnt;

  logic [LANES-1:0]        w_hit;
  logic [LANES-1:0]        w_eff;
  logic [LANES-1:0]        w_vout;
  logic                    w_full;
  logic                    w_emit;
  logic [LANES*DATA_W-1:0] w_group;

  // The word arriving this cycle is folded into the group so a full or
  // flushed emit includes it without waiting for the buffer write.
  always_comb begin
    w_hit   = valid_in ? ({{(LANES-1){1'b0}}, 1'b1} << r_ptr) : '0;
    w_eff   = r_mask | w_hit;
    w_full  = valid_in && (r_ptr == PTR_W'(LANES-1));
    w_emit  = w_full || (flush && (w_eff != '0));
    w_vout  = w_full ? '1 : w_eff;
    w_group = '0;
    for (int k = 0; k < LANES; k++) begin
      if (w_vout[k])
        w_group[k*DATA_W +: DATA_W] = w_hit[k] ? data_in : r_buf[k];
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      r_ptr  <= '0;
      r_mask <= '0;
      r_dout <= '0;
      r_vout <= '0;
      r_busy <= 1'b0;
      r_cnt  <= '0;
      for (int k = 0; k < LANES; k++) r_buf[k] <= '0;
    end else begin
      r_vout <= w_emit ? w_vout : '0;
      if (w_emit) begin
        r_dout <= w_group;
        r_cnt  <= r_cnt + CNT_W'(1);
        r_mask <= '0;
        r_ptr  <= '0;
        r_busy <= 1'b0;
      end else begin
        if (valid_in) begin
          r_buf[r_ptr] <= data_in;
          r_mask       <= w_eff;
          r_ptr        <= r_ptr + PTR_W'(1);
        end
        r_busy <= (w_eff != '0);
      end
    end
  end

  assign data_out   = r_dout;
  assign valid_out  = r_vout;
  assign out_strobe = |r_vout;
  assign busy       = r_busy;
  assign group_cnt  = r_cnt;

endmodule

// File: tb/tb_demux_rr_lanes.sv
// Directed bench for demux_rr_lanes: expected groups are queued as stimulus is
// driven and compared when the DUT strobes (4-lane and 2-lane instances).
module tb_demux_rr_lanes;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  v;
    logic [7:0]  c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [7:0]  a_din = '0;
  logic        a_vin = 1'b0;
  logic        a_fl  = 1'b0;
  logic [31:0] a_dout;
  logic [3:0]  a_vout;
  logic        a_stb;
  logic        a_busy;
  logic [7:0]  a_cnt;

  logic [7:0]  b_din = '0;
  logic        b_vin = 1'b0;
  logic        b_fl  = 1'b0;
  logic [15:0] b_dout;
  logic [1:0]  b_vout;
  logic        b_stb;
  logic        b_busy;
  logic [1:0]  b_cnt;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;
  int          n_chk = 0;
  int          n_err = 0;

  demux_rr_lanes #(.DATA_W(8), .LANES(4), .CNT_W(8)) u_a (
    .clk_4f(clk), .reset(rst), .data_in(a_din), .valid_in(a_vin), .flush(a_fl),
    .data_out(a_dout), .valid_out(a_vout), .out_strobe(a_stb), .busy(a_busy),
    .group_cnt(a_cnt)
  );

  demux_rr_lanes #(.DATA_W(8), .LANES(2), .CNT_W(2)) u_b (
    .clk_4f(clk), .reset(rst), .data_in(b_din), .valid_in(b_vin), .flush(b_fl),
    .data_out(b_dout), .valid_out(b_vout), .out_strobe(b_stb), .busy(b_busy),
    .group_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    chk("a_strobe", {63'd0, a_stb}, {63'd0, qa.size() != 0});
    if (qa.size() != 0) begin
      e = qa.pop_front();
      last_a = e.d;
      if (a_stb) begin
        chk("a_data", {32'd0, a_dout}, {32'd0, e.d});
        chk("a_valid", {60'd0, a_vout}, {60'd0, e.v});
        chk("a_cnt", {56'd0, a_cnt}, {56'd0, e.c});
      end
    end else begin
      chk("a_valid_idle", {60'd0, a_vout}, 64'd0);
      chk("a_data_held", {32'd0, a_dout}, {32'd0, last_a});
    end
    chk("b_strobe", {63'd0, b_stb}, {63'd0, qb.size() != 0});
    if (qb.size() != 0) begin
      e = qb.pop_front();
      last_b = e.d;
      if (b_stb) begin
        chk("b_data", {48'd0, b_dout}, {32'd0, e.d});
        chk("b_valid", {62'd0, b_vout}, {60'd0, e.v});
        chk("b_cnt", {62'd0, b_cnt}, {56'd0, e.c});
      end
    end else begin
      chk("b_valid_idle", {62'd0, b_vout}, 64'd0);
      chk("b_data_held", {48'd0, b_dout}, {32'd0, last_b});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic send(input logic [7:0] d, input logic fl);
    a_din = d; a_vin = 1'b1; a_fl = fl;
    tick();
    a_vin = 1'b0; a_fl = 1'b0; a_din = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data"}, {32'd0, a_dout}, 64'd0);
    chk({tag, "_valid"}, {60'd0, a_vout}, 64'd0);
    chk({tag, "_strobe"}, {63'd0, a_stb}, 64'd0);
    chk({tag, "_busy"}, {63'd0, a_busy}, 64'd0);
    chk({tag, "_cnt"}, {56'd0, a_cnt}, 64'd0);
  endtask

  initial begin
    // Reset state
    #2;
    check_zero("reset");
    idle(2);
    #3 rst = 1'b0;
    idle(1);

    // T1: one full group
    send(8'hA0, 1'b0);
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    qa.push_back('{d: 32'hA3A2A1A0, v: 4'hF, c: 8'd1});
    send(8'hA3, 1'b0);
    chk("t1_busy_after_emit", {63'd0, a_busy}, 64'd0);
    idle(2);

    // T2: gap mid-group keeps lane alignment
    send(8'h10, 1'b0);
    send(8'h11, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_busy_gap", {63'd0, a_busy}, 64'd1);
    end
    send(8'h12, 1'b0);
    qa.push_back('{d: 32'h13121110, v: 4'hF, c: 8'd2});
    send(8'h13, 1'b0);
    idle(1);

    // T3: flush a partial group, next word lands in lane 0
    send(8'h20, 1'b0);
    send(8'h21, 1'b0);
    a_fl = 1'b1;
    qa.push_back('{d: 32'h00002120, v: 4'h3, c: 8'd3});
    tick();
    a_fl = 1'b0;
    chk("t3_busy_after_flush", {63'd0, a_busy}, 64'd0);
    send(8'h30, 1'b0);
    send(8'h31, 1'b0);
    send(8'h32, 1'b0);
    qa.push_back('{d: 32'h33323130, v: 4'hF, c: 8'd4});
    send(8'h33, 1'b0);

    // T4: flush on empty buffer, then flush coinciding with a full group
    a_fl = 1'b1;
    tick();
    a_fl = 1'b0;
    chk("t4_cnt_unchanged", {56'd0, a_cnt}, 64'd4);
    send(8'h50, 1'b0);
    send(8'h51, 1'b0);
    send(8'h52, 1'b0);
    qa.push_back('{d: 32'h53525150, v: 4'hF, c: 8'd5});
    send(8'h53, 1'b1);
    idle(2);
    chk("t4_cnt_single", {56'd0, a_cnt}, 64'd5);

    // T5: asynchronous reset mid-group discards the partial group
    send(8'h40, 1'b0);
    send(8'h41, 1'b0);
    chk("t5_busy_pre", {63'd0, a_busy}, 64'd1);
    #3 rst = 1'b1;
    last_a = '0; last_b = '0;
    #1;
    check_zero("t5_async");
    tick();
    #3 rst = 1'b0;
    send(8'h60, 1'b0);
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    qa.push_back('{d: 32'h63626160, v: 4'hF, c: 8'd1});
    send(8'h63, 1'b0);
    idle(1);

    // T6: two-lane instance with a 2-bit wrapping counter
    for (int i = 0; i < 10; i++) begin
      b_din = 8'h70 + 8'(i);
      b_vin = 1'b1;
      if (i % 2 == 1)
        qb.push_back('{d: {16'd0, 8'h70 + 8'(i), 8'h6F + 8'(i)}, v: 4'h3,
                       c: 8'(((i + 1) / 2) % 4)});
      tick();
    end
    b_vin = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
